// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: width defaults,
// FSM encoding and the write-back slot priority match.
package rf_pkg;

  localparam int CPU_WIDTH      = 64;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int RF_XLEN        = CPU_WIDTH;
  localparam int RF_AW          = REG_ADDR_WIDTH;
  // Widest address the match helper accepts; callers zero-extend to this.
  localparam int RF_AW_MAX      = 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_e;

  // One-hot hit vector; slot 1 is the newer write-back and shadows slot 0.
  function automatic logic [1:0] rf_wb_match(
    input logic [1:0]           wr_act,
    input logic [RF_AW_MAX-1:0] waddr0,
    input logic [RF_AW_MAX-1:0] waddr1,
    input logic [RF_AW_MAX-1:0] raddr
  );
    logic [1:0] hit;
    hit[1] = wr_act[1] && (waddr1 == raddr);
    hit[0] = wr_act[0] && (waddr0 == raddr) && !hit[1];
    return hit;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// Single read port: x0 / range / INIT masking, optional write-back bypass
// and rbusy masking (bypass compiled in with RF_WB_BYPASS_EN).
module rf_read_port
  import rf_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int AW    = RF_AW,
  parameter int DEPTH = 32
) (
  input  logic            run,
  input  logic [AW-1:0]   raddr,
  input  logic [XLEN-1:0] stored,
  input  logic            busy_bit,
  input  logic [1:0]      wr_act,
  input  logic [AW-1:0]   waddr0,
  input  logic [AW-1:0]   waddr1,
  input  logic [XLEN-1:0] wdata0,
  input  logic [XLEN-1:0] wdata1,
  output logic [XLEN-1:0] rdata,
  output logic            rbusy
);

  logic in_range;
  logic valid;

  assign in_range = ({1'b0, raddr} < (AW+1)'(DEPTH));
  assign valid    = run && in_range && (raddr != '0);

`ifdef RF_WB_BYPASS_EN
  logic [1:0] hit;

  assign hit = rf_wb_match(wr_act, RF_AW_MAX'(waddr0), RF_AW_MAX'(waddr1),
                           RF_AW_MAX'(raddr));

  always_comb begin
    rdata = '0;
    rbusy = 1'b0;
    if (valid) begin
      if (hit[1])      rdata = wdata1;
      else if (hit[0]) rdata = wdata0;
      else             rdata = stored;
      // A write landing this cycle resolves the hazard for the reader.
      rbusy = busy_bit && !(|hit);
    end
  end
`else
  logic unused_bypass;

  assign unused_bypass = ^{wr_act, waddr0, waddr1, wdata0, wdata1};

  always_comb begin
    rdata = '0;
    rbusy = 1'b0;
    if (valid) begin
      rdata = stored;
      rbusy = busy_bit;
    end
  end
`endif

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read, dual write-back register file with busy scoreboard and a
// post-reset zero sweep. Optional macro RF_WB_BYPASS_EN adds write-to-read forwarding.
module regfile_mp_sb
  import rf_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int AW    = RF_AW,
  parameter int DEPTH = 32,
  parameter int NRD   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    init_done,
  input  logic [1:0]              wen,
  input  logic [2*AW-1:0]         waddr,
  input  logic [2*XLEN-1:0]       wdata,
  input  logic [NRD*AW-1:0]       raddr,
  output logic [NRD*XLEN-1:0]     rdata,
  output logic [NRD-1:0]          rbusy,
  input  logic                    iss_valid,
  input  logic [AW-1:0]           iss_rd,
  output logic [$clog2(DEPTH):0]  busy_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  rf_state_e         state, state_nxt;
  logic              run;
  logic [AW-1:0]     ptr;
  logic [XLEN-1:0]   regs [DEPTH];

  logic [AW-1:0]     wa [2];
  logic [XLEN-1:0]   wd [2];
  logic [1:0]        wr_act;

  logic [DEPTH-1:0]  busy, busy_nxt, set_vec, clr_vec, rises, falls;
  logic [CW-1:0]     n_set, n_clr, busy_cnt_nxt;

  // ---------------- FSM: state register / next state / outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == INIT && ptr == LAST) state_nxt = RUN;
  end

  always_comb begin
    run       = (state == RUN);
    init_done = (state == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            ptr <= '0;
    else if (state == INIT && ptr != LAST) ptr <= ptr + 1'b1;
  end

  // ---------------- write-back decode
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      wa[k]     = waddr[k*AW +: AW];
      wd[k]     = wdata[k*XLEN +: XLEN];
      wr_act[k] = run && wen[k] && (wa[k] != '0) &&
                  ({1'b0, wa[k]} < (AW+1)'(DEPTH));
    end
  end

  // Slot 1 is applied last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      regs[ptr] <= '0;
    end else begin
      for (int k = 0; k < 2; k++)
        if (wr_act[k]) regs[wa[k]] <= wd[k];
    end
  end

  // ---------------- scoreboard
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int i = 1; i < DEPTH; i++) begin
      set_vec[i] = run && iss_valid && (iss_rd == AW'(i));
      clr_vec[i] = (wr_act[0] && wa[0] == AW'(i)) ||
                   (wr_act[1] && wa[1] == AW'(i));
    end
    // Issue is younger than the write-back, so set overrides clear.
    busy_nxt = (busy & ~clr_vec) | set_vec;
    rises    = busy_nxt & ~busy;
    falls    = busy & ~busy_nxt;
  end

  // Counting actual transitions keeps busy_cnt equal to popcount(busy).
  always_comb begin
    n_set = '0;
    n_clr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      n_set = n_set + CW'(rises[i]);
      n_clr = n_clr + CW'(falls[i]);
    end
    busy_cnt_nxt = busy_cnt + n_set - n_clr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= busy_cnt_nxt;
    end
  end

  // ---------------- read ports
  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = raddr[g*AW +: AW];

    rf_read_port #(
      .XLEN  (XLEN),
      .AW    (AW),
      .DEPTH (DEPTH)
    ) u_rd (
      .run      (run),
      .raddr    (ra),
      .stored   (regs[ra]),
      .busy_bit (busy[ra]),
      .wr_act   (wr_act),
      .waddr0   (wa[0]),
      .waddr1   (wa[1]),
      .wdata0   (wd[0]),
      .wdata1   (wd[1]),
      .rdata    (rdata[g*XLEN +: XLEN]),
      .rbusy    (rbusy[g])
    );
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Randomised bench for regfile_mp_sb: a behavioural register-file model
// feeds an expected queue that a negedge monitor drains and compares.
`timescale 1ns/1ps
module tb_regfile_mp_sb;

  localparam int XLEN  = 64;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int NRD   = 2;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int EW    = NRD*XLEN + NRD + CW + 1;

  logic                 clk;
  logic                 rst_n;
  logic                 init_done;
  logic [1:0]           wen;
  logic [2*AW-1:0]      waddr;
  logic [2*XLEN-1:0]    wdata;
  logic [NRD*AW-1:0]    raddr;
  logic [NRD*XLEN-1:0]  rdata;
  logic [NRD-1:0]       rbusy;
  logic                 iss_valid;
  logic [AW-1:0]        iss_rd;
  logic [CW-1:0]        busy_cnt;

  regfile_mp_sb #(
    .XLEN  (XLEN),
    .AW    (AW),
    .DEPTH (DEPTH),
    .NRD   (NRD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_done (init_done),
    .wen       (wen),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr     (raddr),
    .rdata     (rdata),
    .rbusy     (rbusy),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .busy_cnt  (busy_cnt)
  );

  // ---------------- clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model
  logic [XLEN-1:0] m_mem  [DEPTH];
  bit              m_busy [DEPTH];
  int              m_edges;

  logic [EW-1:0]   exp_q[$];
  int              checks;
  int              errors;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_edges = 0;
  endtask

  function automatic logic [EW-1:0] expect_now();
    logic [NRD*XLEN-1:0] rd;
    logic [NRD-1:0]      rb;
    int                  cnt;
    bit                  run;
    rd  = '0;
    rb  = '0;
    cnt = 0;
    run = 1'b0;
    if (rst_n) begin
      run = (m_edges >= DEPTH);
      for (int i = 0; i < DEPTH; i++) if (m_busy[i]) cnt++;
      for (int p = 0; p < NRD; p++) begin
        int              a;
        logic [XLEN-1:0] v;
        bit              b;
        a = int'(raddr[p*AW +: AW]);
        if (run && a != 0 && a < DEPTH) begin
          v = m_mem[a];
          b = m_busy[a];
`ifdef RF_WB_BYPASS_EN
          for (int k = 0; k < 2; k++)
            if (wen[k] && int'(waddr[k*AW +: AW]) == a) begin
              v = wdata[k*XLEN +: XLEN];
              b = 1'b0;
            end
`endif
          rd[p*XLEN +: XLEN] = v;
          rb[p] = b;
        end
      end
    end
    return {run, CW'(cnt), rb, rd};
  endfunction

  task automatic model_edge();
    if (!rst_n) return;
    if (m_edges < DEPTH) begin
      m_edges++;
      return;
    end
    for (int k = 0; k < 2; k++) begin
      int a;
      a = int'(waddr[k*AW +: AW]);
      if (wen[k] && a != 0 && a < DEPTH) begin
        m_mem[a]  = wdata[k*XLEN +: XLEN];
        m_busy[a] = 1'b0;
      end
    end
    if (iss_valid && iss_rd != '0 && int'(iss_rd) < DEPTH) m_busy[iss_rd] = 1'b1;
  endtask

  // ---------------- driver tasks (called at posedge + 1)
  task automatic step();
    exp_q.push_back(expect_now());
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic [1:0] we, input int a0, input int a1,
                       input logic [XLEN-1:0] d0, input logic [XLEN-1:0] d1,
                       input logic iv, input int ird, input int r0, input int r1);
    wen       = we;
    waddr     = {AW'(a1), AW'(a0)};
    wdata     = {d1, d0};
    iss_valid = iv;
    iss_rd    = AW'(ird);
    raddr     = {AW'(r1), AW'(r0)};
    step();
  endtask

  function automatic logic [XLEN-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic rand_cycle();
    int a0, a1;
    a0 = $urandom_range(0, DEPTH-1);
    a1 = ($urandom_range(0, 3) == 0) ? a0 : $urandom_range(0, DEPTH-1);
    drive(2'($urandom_range(0, 3)), a0, a1, rnd64(), rnd64(),
          1'($urandom_range(0, 1)), $urandom_range(0, DEPTH-1),
          ($urandom_range(0, 1) != 0) ? a1 : $urandom_range(0, DEPTH-1),
          ($urandom_range(0, 1) != 0) ? a0 : $urandom_range(0, DEPTH-1));
  endtask

  task automatic idle_cycle();
    drive(2'b00, 0, 0, '0, '0, 1'b0, 0,
          $urandom_range(0, DEPTH-1), $urandom_range(0, DEPTH-1));
  endtask

  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    repeat (n) idle_cycle();
    rst_n = 1'b1;
  endtask

  // ---------------- scoreboard / monitor
  function automatic void chk(input string name, input logic [XLEN-1:0] act,
                              input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int p = 0; p < NRD; p++) begin
        chk($sformatf("rdata%0d", p), rdata[p*XLEN +: XLEN], e[p*XLEN +: XLEN]);
        chk($sformatf("rbusy%0d", p), XLEN'(rbusy[p]), XLEN'(e[NRD*XLEN + p]));
      end
      chk("busy_cnt", XLEN'(busy_cnt), XLEN'(e[NRD*XLEN + NRD +: CW]));
      chk("init_done", XLEN'(init_done), XLEN'(e[EW-1]));
    end
  end

  // ---------------- stimulus
  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    wen       = '0;
    waddr     = '0;
    wdata     = '0;
    raddr     = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
    model_reset();
    @(posedge clk);
    #1;

    // Sweep: inputs during INIT must be ignored and reads must be zero.
    apply_reset(2);
    repeat (DEPTH) rand_cycle();
    repeat (3) idle_cycle();

    // Dual write to the same register, slot 1 wins, same-cycle read.
    drive(2'b11, 5, 5, 64'h11, 64'h22, 1'b0, 0, 5, 5);
    drive(2'b00, 0, 0, '0, '0, 1'b0, 0, 5, 0);

    // Issue sets busy, write-back clears it.
    drive(2'b00, 0, 0, '0, '0, 1'b1, 7, 7, 0);
    drive(2'b01, 7, 0, 64'hABCD, '0, 1'b0, 0, 7, 7);
    drive(2'b00, 0, 0, '0, '0, 1'b0, 0, 7, 0);

    // Same-cycle set and clear on a busy register: set wins.
    drive(2'b00, 0, 0, '0, '0, 1'b1, 9, 9, 0);
    drive(2'b01, 9, 0, 64'h99, '0, 1'b1, 9, 9, 0);
    drive(2'b00, 0, 0, '0, '0, 1'b0, 0, 9, 0);

    // Both slots clearing the same busy register decrement once.
    drive(2'b11, 9, 9, 64'h1, 64'h2, 1'b0, 0, 9, 9);
    drive(2'b00, 0, 0, '0, '0, 1'b0, 0, 9, 0);

    // x0 is never written nor busy.
    drive(2'b11, 0, 0, 64'hDEAD, 64'hBEEF, 1'b1, 0, 0, 0);
    drive(2'b00, 0, 0, '0, '0, 1'b0, 0, 0, 0);

    repeat (600) rand_cycle();

    // Reset at sweep pointer 10 restarts the sweep.
    apply_reset(2);
    repeat (10) rand_cycle();
    apply_reset(2);
    repeat (DEPTH + 2) rand_cycle();
    repeat (300) rand_cycle();

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
